// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32 multi-cycle
// datapath. It drives every datapath select and write strobe, and it runs the
// shared memory port handshake with a timeout that halts the core. It also
// keeps the cycle and retired-instruction counters.
//
// Build option: define MULTICYCLE_ILLEGAL_TRAP_EN to trap and halt on an
// unsupported opcode. When the macro is undefined, such an opcode retires as a
// NOP.
module multicycle_ctrl #(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       ir_opcode,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             ir_we,
  output logic             mdr_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic             alu_src_imm,
  output logic             alu_src_pc,
  output logic [2:0]       imm_fmt,
  output logic [2:0]       state_o,
  output logic             halted,
  output logic             trap,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  localparam int unsigned WAIT_W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_BR    = 2'd1;
  localparam logic [1:0] PC_JAL   = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MDR = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [2:0] IMM_NONE = 3'd0;
  localparam logic [2:0] IMM_I    = 3'd1;
  localparam logic [2:0] IMM_S    = 3'd2;
  localparam logic [2:0] IMM_SB   = 3'd3;
  localparam logic [2:0] IMM_U    = 3'd4;
  localparam logic [2:0] IMM_UJ   = 3'd5;

  logic [2:0]        state;
  logic [2:0]        state_nx;
  logic [6:0]        op_q;
  logic [6:0]        op;
  logic              op_legal;
  logic [WAIT_W-1:0] wait_cnt;
  logic              wait_expired;
  logic              trap_set;

  // Immediate format selected for each supported opcode
  function automatic logic [2:0] imm_of(input logic [6:0] opc);
    case (opc)
      OP_I, OP_LW: imm_of = IMM_I;
      OP_SW:       imm_of = IMM_S;
      OP_BR:       imm_of = IMM_SB;
      OP_AUIPC:    imm_of = IMM_U;
      OP_JAL:      imm_of = IMM_UJ;
      default:     imm_of = IMM_NONE;
    endcase
  endfunction

  // Opcodes that the datapath can execute
  function automatic logic is_legal(input logic [6:0] opc);
    case (opc)
      OP_R, OP_I, OP_AUIPC, OP_LW, OP_SW, OP_BR, OP_JAL: is_legal = 1'b1;
      default:                                           is_legal = 1'b0;
    endcase
  endfunction

  assign state_o = state;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nx;
  end

  // Opcode latched in DECODE, so later states do not depend on the IR input
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    op_q <= 7'd0;
    else if (state == S_DECODE) op_q <= ir_opcode;
  end

  // Memory wait counter: counts consecutive not-ready cycles while a request stays pending
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      wait_cnt <= '0;
    else if ((state == S_FETCH || state == S_MEM) && !mem_ready && state_nx == state)
      wait_cnt <= wait_cnt + WAIT_W'(1);
    else
      wait_cnt <= '0;
  end

  assign wait_expired = (wait_cnt == WAIT_W'(WAIT_MAX));

  // Next-state and datapath control decode
  always_comb begin
    state_nx    = state;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    addr_sel    = 1'b0;
    ir_we       = 1'b0;
    mdr_we      = 1'b0;
    pc_we       = 1'b0;
    pc_sel      = PC_PLUS4;
    reg_we      = 1'b0;
    wb_sel      = WB_ALU;
    alu_src_imm = 1'b0;
    alu_src_pc  = 1'b0;
    imm_fmt     = IMM_NONE;
    trap_set    = 1'b0;
    op          = (state == S_DECODE) ? ir_opcode : op_q;
    op_legal    = is_legal(op);

    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we    = 1'b1;
          state_nx = S_DECODE;
        end else if (wait_expired) begin
          state_nx = S_HALT;
        end
      end

      S_DECODE: begin
        imm_fmt = imm_of(op);
        if (op_legal) begin
          state_nx = S_EXEC;
        end else begin
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
          trap_set = 1'b1;
          state_nx = S_HALT;
`else
          pc_we    = 1'b1;
          pc_sel   = PC_PLUS4;
          state_nx = S_FETCH;
`endif
        end
      end

      S_EXEC: begin
        imm_fmt = imm_of(op);
        case (op)
          OP_R: begin
            wb_sel   = WB_ALU;
            state_nx = S_WB;
          end
          OP_I: begin
            wb_sel      = WB_ALU;
            alu_src_imm = 1'b1;
            state_nx    = S_WB;
          end
          OP_AUIPC: begin
            alu_src_pc  = 1'b1;
            alu_src_imm = 1'b1;
            state_nx    = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_src_imm = 1'b1;
            state_nx    = S_MEM;
          end
          OP_BR: begin
            pc_we    = 1'b1;
            pc_sel   = branch_taken ? PC_BR : PC_PLUS4;
            state_nx = S_FETCH;
          end
          OP_JAL: begin
            reg_we   = 1'b1;
            wb_sel   = WB_PC4;
            pc_we    = 1'b1;
            pc_sel   = PC_JAL;
            state_nx = S_FETCH;
          end
          default: state_nx = S_FETCH;
        endcase
      end

      S_MEM: begin
        imm_fmt  = imm_of(op);
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = (op == OP_SW);
        if (mem_ready) begin
          if (op == OP_SW) begin
            pc_we    = 1'b1;
            pc_sel   = PC_PLUS4;
            state_nx = S_FETCH;
          end else begin
            mdr_we   = 1'b1;
            state_nx = S_WB;
          end
        end else if (wait_expired) begin
          state_nx = S_HALT;
        end
      end

      S_WB: begin
        imm_fmt  = imm_of(op);
        reg_we   = 1'b1;
        wb_sel   = (op == OP_LW) ? WB_MDR : WB_ALU;
        pc_we    = 1'b1;
        pc_sel   = PC_PLUS4;
        state_nx = S_FETCH;
      end

      S_HALT: state_nx = S_HALT;

      default: state_nx = S_FETCH;
    endcase

    // Reset forces every strobe low at once, without waiting for a clock edge
    if (rst) begin
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      addr_sel    = 1'b0;
      ir_we       = 1'b0;
      mdr_we      = 1'b0;
      pc_we       = 1'b0;
      pc_sel      = PC_PLUS4;
      reg_we      = 1'b0;
      wb_sel      = WB_ALU;
      alu_src_imm = 1'b0;
      alu_src_pc  = 1'b0;
      imm_fmt     = IMM_NONE;
      trap_set    = 1'b0;
    end
  end

  // Sticky halt flag, set when the FSM enters HALT
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     halted <= 1'b0;
    else if (state_nx == S_HALT) halted <= 1'b1;
  end

  // Sticky illegal-opcode flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           trap <= 1'b0;
    else if (trap_set) trap <= 1'b1;
  end

  // Cycle counter, frozen while halted
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  cycle_cnt <= '0;
    else if (state != S_HALT) cycle_cnt <= cycle_cnt + CNT_W'(1);
  end

  // Retire counter: one count per PC update
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        instret_cnt <= '0;
    else if (pc_we) instret_cnt <= instret_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl. The stimulus pushes one hand-computed
// expected output vector per cycle. The monitor samples on the falling edge
// and compares.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  ir_opcode;
  logic        branch_taken;
  logic        mem_ready;
  logic        mem_req, mem_we, addr_sel, ir_we, mdr_we, pc_we, reg_we;
  logic [1:0]  pc_sel, wb_sel;
  logic        alu_src_imm, alu_src_pc, halted, trap;
  logic [2:0]  imm_fmt, state_o;
  logic [31:0] cycle_cnt, instret_cnt;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .ir_opcode(ir_opcode), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
    .ir_we(ir_we), .mdr_we(mdr_we), .pc_we(pc_we), .pc_sel(pc_sel), .reg_we(reg_we),
    .wb_sel(wb_sel), .alu_src_imm(alu_src_imm), .alu_src_pc(alu_src_pc),
    .imm_fmt(imm_fmt), .state_o(state_o), .halted(halted), .trap(trap),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [20:0] sig;
    logic [31:0] cyc;
    logic [31:0] ins;
    string       tag;
  } exp_t;

  exp_t        exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] ecyc     = 0;
  logic [31:0] eins     = 0;

  // Packs an expected output vector: state, strobes and selects, imm_fmt, halted, trap
  function automatic logic [20:0] ex(input logic [2:0] st, input logic req, we, asel, irwe,
                                     mdrwe, pcwe, input logic [1:0] pcsel, input logic regwe,
                                     input logic [1:0] wbsel, input logic aimm, apc,
                                     input logic [2:0] imm, input logic h, t);
    return {st, req, we, asel, irwe, mdrwe, pcwe, pcsel, regwe, wbsel, aimm, apc, imm, h, t};
  endfunction

  // Drives one cycle of inputs and queues the expected outputs for that cycle
  task automatic step(input logic rdy, input logic br, input logic [20:0] s, input string tag);
    exp_t e;
    mem_ready    = rdy;
    branch_taken = br;
    e.sig = s; e.cyc = ecyc; e.ins = eins; e.tag = tag;
    exp_q.push_back(e);
    if (s[20:18] != 3'd5) ecyc = ecyc + 1;
    if (s[12])            eins = eins + 1;
    @(posedge clk); #1;
  endtask

  // Holds reset for one cycle. All outputs and counters are expected at zero.
  task automatic rst_cycle(input string tag);
    exp_t e;
    rst = 1'b1;
    e.sig = '0; e.cyc = 0; e.ins = 0; e.tag = tag;
    exp_q.push_back(e);
    ecyc = 0; eins = 0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Monitor: compare every queued cycle
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t        e;
      logic [20:0] act;
      e   = exp_q.pop_front();
      act = {state_o, mem_req, mem_we, addr_sel, ir_we, mdr_we, pc_we, pc_sel, reg_we,
             wb_sel, alu_src_imm, alu_src_pc, imm_fmt, halted, trap};
      checks++;
      if (act !== e.sig) begin
        failures++;
        $display("FAIL %s outputs: got %b expected %b", e.tag, act, e.sig);
      end
      checks++;
      if (cycle_cnt !== e.cyc || instret_cnt !== e.ins) begin
        failures++;
        $display("FAIL %s counters: got cyc=%0d ins=%0d expected cyc=%0d ins=%0d",
                 e.tag, cycle_cnt, instret_cnt, e.cyc, e.ins);
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ir_opcode = 7'd0; branch_taken = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    rst_cycle("reset");

    // addi: FETCH, DECODE, EXEC, WB
    ir_opcode = 7'b0010011;
    step(1, 0, ex(0,1,0,0,1,0,0,0,0,0,0,0,0,0,0), "addi_fetch");
    step(1, 0, ex(1,0,0,0,0,0,0,0,0,0,0,0,1,0,0), "addi_decode");
    step(1, 0, ex(2,0,0,0,0,0,0,0,0,0,1,0,1,0,0), "addi_exec");
    step(1, 0, ex(4,0,0,0,0,0,1,0,1,0,0,0,1,0,0), "addi_wb");

    // lw: 3 FETCH waits and 2 MEM waits, 10 cycles in total
    ir_opcode = 7'b0000011;
    for (int i = 0; i < 3; i++) step(0, 0, ex(0,1,0,0,0,0,0,0,0,0,0,0,0,0,0), "lw_fetch_wait");
    step(1, 0, ex(0,1,0,0,1,0,0,0,0,0,0,0,0,0,0), "lw_fetch");
    step(1, 0, ex(1,0,0,0,0,0,0,0,0,0,0,0,1,0,0), "lw_decode");
    step(1, 0, ex(2,0,0,0,0,0,0,0,0,0,1,0,1,0,0), "lw_exec");
    for (int i = 0; i < 2; i++) step(0, 0, ex(3,1,0,1,0,0,0,0,0,0,0,0,1,0,0), "lw_mem_wait");
    step(1, 0, ex(3,1,0,1,0,1,0,0,0,0,0,0,1,0,0), "lw_mem");
    step(1, 0, ex(4,0,0,0,0,0,1,0,1,1,0,0,1,0,0), "lw_wb");

    // beq taken, then beq not taken
    ir_opcode = 7'b1100011;
    step(1, 0, ex(0,1,0,0,1,0,0,0,0,0,0,0,0,0,0), "beqt_fetch");
    step(1, 0, ex(1,0,0,0,0,0,0,0,0,0,0,0,3,0,0), "beqt_decode");
    step(1, 1, ex(2,0,0,0,0,0,1,1,0,0,0,0,3,0,0), "beqt_exec");
    step(1, 0, ex(0,1,0,0,1,0,0,0,0,0,0,0,0,0,0), "beqn_fetch");
    step(1, 0, ex(1,0,0,0,0,0,0,0,0,0,0,0,3,0,0), "beqn_decode");
    step(1, 0, ex(2,0,0,0,0,0,1,0,0,0,0,0,3,0,0), "beqn_exec");

    // jal
    ir_opcode = 7'b1101111;
    step(1, 0, ex(0,1,0,0,1,0,0,0,0,0,0,0,0,0,0), "jal_fetch");
    step(1, 0, ex(1,0,0,0,0,0,0,0,0,0,0,0,5,0,0), "jal_decode");
    step(1, 0, ex(2,0,0,0,0,0,1,2,1,2,0,0,5,0,0), "jal_exec");

    // sw
    ir_opcode = 7'b0100011;
    step(1, 0, ex(0,1,0,0,1,0,0,0,0,0,0,0,0,0,0), "sw_fetch");
    step(1, 0, ex(1,0,0,0,0,0,0,0,0,0,0,0,2,0,0), "sw_decode");
    step(1, 0, ex(2,0,0,0,0,0,0,0,0,0,1,0,2,0,0), "sw_exec");
    step(1, 0, ex(3,1,1,1,0,0,1,0,0,0,0,0,2,0,0), "sw_mem");

    // auipc
    ir_opcode = 7'b0010111;
    step(1, 0, ex(0,1,0,0,1,0,0,0,0,0,0,0,0,0,0), "auipc_fetch");
    step(1, 0, ex(1,0,0,0,0,0,0,0,0,0,0,0,4,0,0), "auipc_decode");
    step(1, 0, ex(2,0,0,0,0,0,0,0,0,0,1,1,4,0,0), "auipc_exec");
    step(1, 0, ex(4,0,0,0,0,0,1,0,1,0,0,0,4,0,0), "auipc_wb");

    // R-type, with mem_ready high in non-memory states (must be ignored)
    ir_opcode = 7'b0110011;
    step(1, 0, ex(0,1,0,0,1,0,0,0,0,0,0,0,0,0,0), "r_fetch");
    step(1, 0, ex(1,0,0,0,0,0,0,0,0,0,0,0,0,0,0), "r_decode");
    step(1, 0, ex(2,0,0,0,0,0,0,0,0,0,0,0,0,0,0), "r_exec");
    step(1, 0, ex(4,0,0,0,0,0,1,0,1,0,0,0,0,0,0), "r_wb");

    // Unsupported opcode
    ir_opcode = 7'b1111111;
    step(1, 0, ex(0,1,0,0,1,0,0,0,0,0,0,0,0,0,0), "ill_fetch");
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    step(1, 0, ex(1,0,0,0,0,0,0,0,0,0,0,0,0,0,0), "ill_decode");
    step(1, 0, ex(5,0,0,0,0,0,0,0,0,0,0,0,0,1,1), "ill_halt");
    step(1, 0, ex(5,0,0,0,0,0,0,0,0,0,0,0,0,1,1), "ill_halt_hold");
`else
    step(1, 0, ex(1,0,0,0,0,0,1,0,0,0,0,0,0,0,0), "ill_nop_decode");
    step(0, 0, ex(0,1,0,0,0,0,0,0,0,0,0,0,0,0,0), "ill_nop_next");
`endif

    // Reset pulse, then sw aborted by a reset while in MEM
    rst_cycle("rst_pulse");
    ir_opcode = 7'b0100011;
    step(1, 0, ex(0,1,0,0,1,0,0,0,0,0,0,0,0,0,0), "swr_fetch");
    step(1, 0, ex(1,0,0,0,0,0,0,0,0,0,0,0,2,0,0), "swr_decode");
    step(1, 0, ex(2,0,0,0,0,0,0,0,0,0,1,0,2,0,0), "swr_exec");
    step(0, 0, ex(3,1,1,1,0,0,0,0,0,0,0,0,2,0,0), "swr_mem_wait");
    rst_cycle("rst_mid_mem");

    // Memory never ready: 16 request cycles, then HALT with cycle_cnt frozen
    for (int i = 0; i < 16; i++) step(0, 0, ex(0,1,0,0,0,0,0,0,0,0,0,0,0,0,0), "timeout_fetch");
    for (int i = 0; i < 3; i++)  step(0, 0, ex(5,0,0,0,0,0,0,0,0,0,0,0,0,1,0), "timeout_halt");

    @(negedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle sequencer for the RV32 core datapath: register file, ALU, immediate generator, PC and a single shared instruction/data memory port.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives every datapath select and write strobe, including the immediate-format select.
- Handles the memory ready handshake with a timeout, and keeps cycle/retire counters.

Parameters:
- CNT_W, 32, width of cycle_cnt and instret_cnt (wrap at 2^CNT_W).
- WAIT_MAX, 15, maximum consecutive wait cycles on the memory port before halting.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ir_opcode  in  7  opcode field of the instruction register; valid from DECODE onward.
- branch_taken  in  1  ALU compare result; sampled in EXEC of a branch.
- mem_ready  in  1  memory accepts or returns data this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  memory write (store).
- addr_sel  out  1  memory address source: 0 = PC, 1 = ALU result.
- ir_we  out  1  instruction register load.
- mdr_we  out  1  memory data register load.
- pc_we  out  1  PC update; also marks instruction retire.
- pc_sel  out  2  next PC: 0 = PC+4, 1 = branch target, 2 = jal target.
- reg_we  out  1  register file write.
- wb_sel  out  2  writeback source: 0 = ALU, 1 = MDR, 2 = PC+4.
- alu_src_imm  out  1  ALU operand B = imm32.
- alu_src_pc  out  1  ALU operand A = PC.
- imm_fmt  out  3  immediate format: 0 none, 1 I, 2 S, 3 SB, 4 U, 5 UJ.
- state_o  out  3  current state code.
- halted  out  1  sticky halt (memory timeout or trap).
- trap  out  1  sticky illegal-opcode flag.
- cycle_cnt  out  CNT_W  cycles since reset, excluding the HALT state.
- instret_cnt  out  CNT_W  retired instructions.

Behaviour:
- State codes: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- While rst is high: state=FETCH, counters=0, halted=0, trap=0, every strobe/select output forced to 0.
- Outputs are combinational from state, the opcode latched in DECODE, mem_ready and branch_taken.
- Supported opcodes and their EXEC behaviour:
  - 0110011 R: wb_sel=0.
  - 0010011 I-ALU: wb_sel=0, alu_src_imm=1.
  - 0010111 auipc: alu_src_pc=1, alu_src_imm=1.
  - 0000011 lw: alu_src_imm=1.
  - 0100011 sw: alu_src_imm=1.
  - 1100011 branch: no extra selects.
  - 1101111 jal: no extra selects.
- imm_fmt by opcode: lw/I-ALU=1, sw=2, branch=3, auipc=4, jal=5, R=0. It is held from DECODE through WB; it is 0 in FETCH and HALT.
- FETCH: mem_req=1, addr_sel=0. When mem_ready=1: ir_we=1 that cycle, go to DECODE; otherwise stay in FETCH.
- DECODE: latch the opcode, go to EXEC (1 cycle). An unsupported opcode is handled per the optional feature.
- EXEC:
  - R, I-ALU, auipc: go to WB.
  - lw, sw: go to MEM.
  - branch: pc_we=1, pc_sel = branch_taken ? 1 : 0, go to FETCH.
  - jal: reg_we=1, wb_sel=2, pc_we=1, pc_sel=2, go to FETCH.
- MEM: mem_req=1, addr_sel=1, mem_we=1 for sw. Waits for mem_ready.
  - sw: on ready, pc_we=1, pc_sel=0, go to FETCH.
  - lw: on ready, mdr_we=1, go to WB.
- WB: reg_we=1, wb_sel=1 for lw else 0, pc_we=1, pc_sel=0, go to FETCH.
- Latency with zero-wait memory: R/I-ALU/auipc 4 cycles, lw 5, sw 4, branch/jal 3.
- Wait counter:
  - Cleared on every state entry and whenever mem_ready=1.
  - Increments each FETCH/MEM cycle that has mem_ready=0.
  - If mem_ready=0 while the counter equals WAIT_MAX, go to HALT next cycle: mem_req is high for exactly WAIT_MAX+1 cycles.
  - halted=1 latches on entry to HALT.
- HALT: absorbing; all strobes 0; only rst exits.
- Counters:
  - cycle_cnt increments every cycle outside reset and HALT.
  - instret_cnt increments on every pc_we cycle.
  - Both wrap modulo 2^CNT_W.
- Reset mid-operation (e.g. mid-MEM): outputs drop to 0 immediately (asynchronous). The first cycle after release is FETCH with mem_req=1; no write strobe is issued for the aborted instruction.
- A mem_ready=1 outside FETCH/MEM is ignored.

Optional Feature:
- Macro: MULTICYCLE_ILLEGAL_TRAP_EN.
- Defined: an unsupported opcode in DECODE sets trap=1 and halted=1 and goes to HALT; the PC is not updated and instret is not incremented.
- Undefined: an unsupported opcode is a NOP; DECODE asserts pc_we=1, pc_sel=0, goes to FETCH (counts as retired), and trap stays 0.

Test Plan:
- addi (0010011), mem_ready=1 always: states 0,1,2,4,0; imm_fmt=1 from DECODE; single reg_we+pc_we pulse in WB; instret_cnt=1, cycle_cnt=4.
- lw with mem_ready low for 3 FETCH cycles and 2 MEM cycles: total 10 cycles; mdr_we pulse, then WB with wb_sel=1; addr_sel=1 only in MEM.
- beq (1100011): branch_taken=1 gives pc_sel=1 in EXEC; branch_taken=0 gives pc_sel=0; 3 cycles each; no reg_we; imm_fmt=3.
- jal: EXEC has reg_we=1, wb_sel=2, pc_sel=2, imm_fmt=5. sw: MEM has mem_we=1, imm_fmt=2, no reg_we.
- mem_ready held 0 from reset: mem_req high 16 cycles (WAIT_MAX=15), then state_o=5, halted=1, mem_req=0, cycle_cnt frozen at 16.
- Opcode 1111111: with macro, trap=halted=1, instret_cnt unchanged. Without macro, pc_we in DECODE, instret_cnt+1. Also: rst pulse mid-MEM of sw → no mem_we after release, state_o=0.
